// File: rtl/shift_pkg.sv
// Shared types and helpers for the piso_shift_tx serial transmitter.
package shift_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int unsigned DEFAULT_WIDTH = 4;

   // Width able to hold 0..frame; cnt itself never passes frame-1.
   function automatic int unsigned cnt_width(input int unsigned frame);
      return $clog2(frame + 1);
   endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Frame bit counter: loadable up-counter with terminal-count flag at FRAME-1.
module piso_bit_cnt
   import shift_pkg::*;
#(
   parameter int unsigned FRAME = DEFAULT_WIDTH,
   parameter int unsigned CW    = cnt_width(FRAME)
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          i_load,
   input  logic          i_en,
   output logic [CW-1:0] o_cnt,
   output logic          o_tc
);

   logic [CW-1:0] r_cnt;
   logic          w_tc;

   assign w_tc  = (r_cnt == CW'(FRAME - 1));
   assign o_cnt = r_cnt;
   assign o_tc  = w_tc;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and framing outputs.
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module piso_shift_tx
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             ld_valid,
   input  logic [WIDTH-1:0] ld_data,
   output logic             ld_ready,
   output logic             Dout,
   output logic             dout_valid,
   output logic             last_bit,
   output logic             busy
);

`ifdef PISO_PARITY_EN
   localparam int unsigned FRAME = WIDTH + 1;
`else
   localparam int unsigned FRAME = WIDTH;
`endif
   localparam int unsigned CW = cnt_width(FRAME);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [FRAME-1:0] r_shift;
   logic [FRAME-1:0] w_shift_nxt;
   logic [FRAME-1:0] w_load_word;
   logic [FRAME-1:0] w_shifted;
   logic [CW-1:0]    w_cnt;
   logic             w_tc;
   logic             w_busy;
   logic             w_ready;
   logic             w_accept;
   logic             w_head;

   // Parity rides in the shift register's tail slot so it leaves right after the data.
`ifdef PISO_PARITY_EN
   logic w_par;
   assign w_par       = ^ld_data;
   assign w_load_word = (MSB_FIRST != 0) ? {ld_data, w_par} : {w_par, ld_data};
`else
   assign w_load_word = ld_data;
`endif

   assign w_shifted = (MSB_FIRST != 0) ? {r_shift[FRAME-2:0], 1'b0}
                                       : {1'b0, r_shift[FRAME-1:1]};
   assign w_head    = (MSB_FIRST != 0) ? r_shift[FRAME-1] : r_shift[0];

   assign w_busy   = (r_state == SHIFT);
   assign w_ready  = !w_busy || w_tc;
   assign w_accept = ld_valid && w_ready;

   piso_bit_cnt #(
      .FRAME (FRAME),
      .CW    (CW)
   ) u_bit_cnt (
      .clk    (clk),
      .clr_n  (clr_n),
      .i_load (w_accept),
      .i_en   (w_busy),
      .o_cnt  (w_cnt),
      .o_tc   (w_tc)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = SHIFT;
               w_shift_nxt = w_load_word;
            end
         end
         SHIFT: begin
            if (w_accept) begin
               w_shift_nxt = w_load_word;
            end else if (w_tc) begin
               w_state_nxt = IDLE;
               w_shift_nxt = '0;
            end else begin
               w_shift_nxt = w_shifted;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_shift_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state <= IDLE;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   // Outputs decode registered state only, so they change just after the edge.
   assign ld_ready   = w_ready;
   assign busy       = w_busy;
   assign dout_valid = w_busy;
   assign Dout       = w_busy && w_head;
   assign last_bit   = w_busy && w_tc;

   logic w_unused;
   assign w_unused = ^w_cnt;

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
Parallel-in, serial-out shift transmitter. It is the sending end for the team's serial-in shift register (ShiftReg_M).
- Accepts a WIDTH-bit word via a valid/ready load handshake.
- Drives it onto a 1-bit serial line, one bit per clk, with a framing valid and a last-bit marker.
- Sits between a parallel producer (counter, register file, test pattern source) and any serial-in consumer.

Parameters:
- WIDTH, 4: data word width in bits; legal range ≥ 2.
- MSB_FIRST, 1: 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.

Ports:
- clk, input, 1: rising-edge clock, the only clock.
- clr_n, input, 1: asynchronous active-low reset.
- ld_valid, input, 1: producer presents a word on ld_data.
- ld_data, input, WIDTH: parallel word; sampled only on accept.
- ld_ready, output, 1: block can accept a word this cycle.
- Dout, output, 1: serial data bit.
- dout_valid, output, 1: Dout carries a frame bit this cycle.
- last_bit, output, 1: Dout carries the final bit of the frame.
- busy, output, 1: frame in progress (state SHIFT).

Behaviour:
- Reset (clr_n low, asynchronous, takes effect without a clk edge):
  - state = IDLE, shift register = 0, counter = 0.
  - Dout = 0, dout_valid = 0, last_bit = 0, busy = 0.
  - ld_ready = 1 as soon as reset is removed.
- States:
  - IDLE: no frame active.
  - SHIFT: frame active; counter cnt runs 0..FRAME-1.
  - FRAME = WIDTH, or WIDTH+1 when the optional feature is enabled.
- ld_ready is combinational: 1 in IDLE, or in SHIFT when cnt == FRAME-1. Otherwise 0.
- Accept = ld_valid && ld_ready, sampled at the rising edge.
  - On accept, ld_data is loaded into the shift register, cnt = 0, state → SHIFT.
- Latency: a word accepted at edge t drives its first bit from t until t+1. Bits follow on consecutive cycles with no gaps; FRAME cycles total.
- Registered outputs in SHIFT:
  - Dout = current head bit (MSB if MSB_FIRST, else LSB).
  - dout_valid = 1; busy = 1.
  - last_bit = 1 only when cnt == FRAME-1.
- Each edge in SHIFT without accept: shift the register one position toward the head and increment cnt.
- End of frame (cnt == FRAME-1):
  - With accept: load the new word; back-to-back frames are contiguous and dout_valid stays high.
  - Without accept: state → IDLE, Dout = 0, dout_valid = 0.
- While ld_ready = 0, ld_valid is ignored. ld_data may change freely; the in-flight frame is unaffected.
- Reset asserted mid-frame: the frame is aborted and all outputs return to reset values immediately. No partial frame resumes.
- ld_valid held high continuously produces an uninterrupted stream of frames.
- Counter width: clog2(FRAME+1) bits; cnt never exceeds FRAME-1.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - FRAME = WIDTH+1.
  - After the data bits, one even-parity bit is sent: XOR of the loaded word, captured at accept.
  - last_bit marks the parity bit; ld_ready rises on the parity cycle.
- Undefined:
  - FRAME = WIDTH; no parity logic or parity register is generated.

Decomposition:
- Package shift_pkg:
  - state typedef {IDLE, SHIFT}.
  - default WIDTH constant.
  - function computing the counter width from FRAME.
- One natural sub-module: piso_bit_cnt.
  - Loadable up-counter with a terminal-count flag (cnt == FRAME-1).
  - Used by the FSM for last_bit, ld_ready and the return to IDLE.
- The shift register and FSM stay in the top module.

Test Plan:
- Single word (WIDTH=4, MSB_FIRST=1): load 4'b1010 → Dout 1,0,1,0 on 4 consecutive cycles; dout_valid high 4 cycles; last_bit only on the 4th; busy drops after it; ld_ready returns to 1.
- Back-to-back: ld_valid held with 4'b1010 then 4'b0011 → Dout 1,0,1,0,0,0,1,1 with dout_valid high 8 contiguous cycles; last_bit on cycles 4 and 8.
- Ignore while busy: after loading 4'b1100, pulse ld_valid with 4'b0110 at cnt = 1 → stream stays 1,1,0,0; the second word is not accepted.
- LSB first (MSB_FIRST=0): load 4'b1000 → Dout 0,0,0,1.
- Reset mid-frame: load 4'b1111, drop clr_n at cnt = 2 between edges → Dout, dout_valid, busy go 0 immediately. After release: ld_ready = 1, and the next load 4'b0101 transmits correctly from its first bit.
- With PISO_PARITY_EN defined: load 4'b1011 → Dout 1,0,1,1,1 (parity 1); dout_valid 5 cycles; last_bit on the 5th. Load 4'b0110 → parity bit 0.
